// File: rtl/miner_work_sequencer.sv
// miner_work_sequencer
//   Feeds work to a double-SHA pipeline one nonce per cycle and collects the
//   nonces whose returned hash word marks them as golden.
//
//   Parameters
//     PIPE_LATENCY  cycles from a nonce leaving on hasher_data to its hash_word (>= 2)
//     FIFO_DEPTH    golden-nonce FIFO entries, power of two (>= 2)
//
//   Ports
//     hash_clk                  the only clock (rising edge)
//     reset                     asynchronous, active-high reset
//     work_valid/work_ready     work offer handshake (ready = pending slot empty)
//     work_midstate, work_data  offered work
//     hasher_state/hasher_data  registered midstate and {nonce, data} to the pipeline
//     hash_word                 second-hash word [159:128] returned by the pipeline
//     golden_valid/golden_ready golden output handshake
//     golden_nonce/golden_epoch head entry: issued nonce and its work epoch bit
//     exhausted                 active work has issued all 2^32 nonces
//
//   Configuration
//     GOLDEN_FIFO_EN defined   : goldens queue in a FIFO_DEPTH-entry FIFO, drops when full
//     GOLDEN_FIFO_EN undefined : single golden register, newest entry overwrites
module miner_work_sequencer #(
    parameter int unsigned PIPE_LATENCY = 130,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic         hash_clk,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    output logic [255:0] hasher_state,
    output logic [127:0] hasher_data,
    input  logic [31:0]  hash_word,
    output logic         golden_valid,
    input  logic         golden_ready,
    output logic [31:0]  golden_nonce,
    output logic         golden_epoch,
    output logic         exhausted
);

    typedef enum logic [1:0] {StIdle, StRun, StExh} state_t;

    state_t              state_q, state_d;
    logic [31:0]         nonce_cnt_q;
    logic [32:0]         issue_cnt_q;
    logic [255:0]        act_mid_q, pend_mid_q;
    logic [95:0]         act_data_q, pend_data_q;
    logic                epoch_q, pend_full_q;
    logic [255:0]        hasher_state_q;
    logic [127:0]        hasher_data_q;
    logic [PIPE_LATENCY-1:0] tag_valid_q, tag_epoch_q;
    logic                golden_q, golden_tag_epoch_q;
    logic [31:0]         hash_sum;
    logic [31:0]         push_nonce;
    logic                promote, accept, issue;

    // Ready is low whenever pending is full, and pending full forces a
    // promotion, so an accept can never coincide with a promotion.
    assign promote    = pend_full_q;
    assign accept     = work_valid & ~pend_full_q;
    assign issue      = (state_q == StRun);
    assign work_ready = ~pend_full_q;
    assign exhausted  = (state_q == StExh);

    assign hasher_state = hasher_state_q;
    assign hasher_data  = hasher_data_q;

    assign hash_sum = hash_word + 32'h5be0cd19;
    // golden_q is one cycle behind the tag output and the push one more,
    // hence the extra cycle on top of the pipeline latency.
    assign push_nonce = nonce_cnt_q - 32'(PIPE_LATENCY) - 32'd1;

    always_comb begin
        state_d = state_q;
        if (promote) begin
            state_d = StRun;
        end else if (issue && issue_cnt_q == 33'h0_FFFF_FFFF) begin
            state_d = StExh;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            nonce_cnt_q    <= '0;
            issue_cnt_q    <= '0;
            act_mid_q      <= '0;
            act_data_q     <= '0;
            pend_mid_q     <= '0;
            pend_data_q    <= '0;
            epoch_q        <= 1'b0;
            pend_full_q    <= 1'b0;
            hasher_state_q <= '0;
            hasher_data_q  <= '0;
            tag_valid_q    <= '0;
            tag_epoch_q    <= '0;
            golden_q       <= 1'b0;
            golden_tag_epoch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nonce_cnt_q <= nonce_cnt_q + 32'd1;

            if (issue) begin
                hasher_state_q <= act_mid_q;
                hasher_data_q  <= {nonce_cnt_q, act_data_q};
            end
            tag_valid_q <= {tag_valid_q[PIPE_LATENCY-2:0], issue};
            tag_epoch_q <= {tag_epoch_q[PIPE_LATENCY-2:0], epoch_q};

            if (promote) begin
                act_mid_q   <= pend_mid_q;
                act_data_q  <= pend_data_q;
                epoch_q     <= ~epoch_q;
                issue_cnt_q <= '0;
                pend_full_q <= 1'b0;
            end else begin
                if (issue) begin
                    issue_cnt_q <= issue_cnt_q + 33'd1;
                end
                if (accept) begin
                    pend_mid_q  <= work_midstate;
                    pend_data_q <= work_data;
                    pend_full_q <= 1'b1;
                end
            end

            golden_q           <= (hash_sum == 32'h0) & tag_valid_q[PIPE_LATENCY-1];
            golden_tag_epoch_q <= tag_epoch_q[PIPE_LATENCY-1];
        end
    end

`ifdef GOLDEN_FIFO_EN
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   fifo_nonce_q [FIFO_DEPTH];
    logic          fifo_epoch_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q, fill;
    logic          fifo_full, fifo_pop, fifo_push, overflow_q;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign fill         = wr_ptr_q - rd_ptr_q;
    assign fifo_full    = (fill == (PtrW + 1)'(FIFO_DEPTH));
    assign golden_valid = (wr_ptr_q != rd_ptr_q);
    assign fifo_pop     = golden_valid & golden_ready;
    assign fifo_push    = golden_q & (~fifo_full | fifo_pop);
    assign golden_nonce = fifo_nonce_q[rd_ptr_q[PtrW-1:0]];
    assign golden_epoch = fifo_epoch_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_nonce_q[i] <= '0;
                fifo_epoch_q[i] <= 1'b0;
            end
        end else begin
            if (fifo_push) begin
                fifo_nonce_q[wr_ptr_q[PtrW-1:0]] <= push_nonce;
                fifo_epoch_q[wr_ptr_q[PtrW-1:0]] <= golden_tag_epoch_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Sticky until reset: a golden was lost.
            if (golden_q && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end
`else
    logic        gold_valid_q;
    logic [31:0] gold_nonce_q;
    logic        gold_epoch_q;

    assign golden_valid = gold_valid_q;
    assign golden_nonce = gold_nonce_q;
    assign golden_epoch = gold_epoch_q;

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            gold_valid_q <= 1'b0;
            gold_nonce_q <= '0;
            gold_epoch_q <= 1'b0;
        end else if (golden_q) begin
            // A fresh golden wins over a same-cycle pop.
            gold_valid_q <= 1'b1;
            gold_nonce_q <= push_nonce;
            gold_epoch_q <= golden_tag_epoch_q;
        end else if (golden_ready) begin
            gold_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_miner_work_sequencer.sv
// Self-checking bench for miner_work_sequencer. A behavioural model tracks
// which nonce was issued under which work epoch and the expected golden
// contents; a negedge monitor compares the DUT against it every cycle.
module tb_miner_work_sequencer;

    localparam int unsigned LAT   = 130;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'ha41f32e7;  // hash_word + 0x5be0cd19 == 0

    logic         hash_clk = 1'b0;
    logic         reset = 1'b1;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [255:0] hasher_state;
    logic [127:0] hasher_data;
    logic [31:0]  hash_word;
    logic         golden_valid;
    logic         golden_ready;
    logic [31:0]  golden_nonce;
    logic         golden_epoch;
    logic         exhausted;

    always #5 hash_clk = ~hash_clk;

    miner_work_sequencer #(
        .PIPE_LATENCY(LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .work_valid   (work_valid),
        .work_ready   (work_ready),
        .work_midstate(work_midstate),
        .work_data    (work_data),
        .hasher_state (hasher_state),
        .hasher_data  (hasher_data),
        .hash_word    (hash_word),
        .golden_valid (golden_valid),
        .golden_ready (golden_ready),
        .golden_nonce (golden_nonce),
        .golden_epoch (golden_epoch),
        .exhausted    (exhausted)
    );

    typedef struct packed {
        logic [31:0] nonce;
        logic        epoch;
    } gold_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]  m_cnt;
    logic         m_pend, m_run, m_exh, m_epoch, m_ovf;
    logic [255:0] m_pend_mid, m_act_mid, m_hs;
    logic [95:0]  m_pend_data, m_act_data;
    logic [127:0] m_hd;
    logic [32:0]  m_issued;
    bit           issued_ep [logic [31:0]];
    gold_t        exp_q [$];
    bit           push_due;
    gold_t        push_val;
    int           force_seq = 0;
    int           force_seen;
    logic [31:0]  tgt;

    always @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            m_cnt = '0; m_pend = 0; m_run = 0; m_exh = 0; m_epoch = 0; m_ovf = 0;
            m_pend_mid = '0; m_act_mid = '0; m_hs = '0;
            m_pend_data = '0; m_act_data = '0; m_hd = '0; m_issued = '0;
            issued_ep.delete();
            exp_q.delete();
            push_due = 0;
            force_seen = force_seq;
        end else begin
            // Golden store: pop and push happen on the same edge.
            if (golden_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (push_due) begin
`ifdef GOLDEN_FIFO_EN
                if (exp_q.size() < DEPTH) exp_q.push_back(push_val);
                else m_ovf = 1;
`else
                if (exp_q.size() == 0) exp_q.push_back(push_val);
                else exp_q[0] = push_val;
`endif
            end
            // A golden hash word now refers to the nonce issued LAT cycles ago.
            tgt = m_cnt - LAT;
            push_due = (hash_word == MAGIC) && issued_ep.exists(tgt);
            if (push_due) begin
                push_val.nonce = tgt;
                push_val.epoch = issued_ep[tgt];
            end
            if (issued_ep.exists(tgt)) issued_ep.delete(tgt);
            if (force_seq != force_seen) begin
                m_issued = 33'h0_FFFF_FFFE;
                force_seen = force_seq;
            end
            if (m_run) begin
                issued_ep[m_cnt] = m_epoch;
                m_hd = {m_cnt, m_act_data};
                m_hs = m_act_mid;
                m_issued = m_issued + 33'd1;
                if (m_issued == 33'h1_0000_0000) begin
                    m_run = 0;
                    m_exh = 1;
                end
            end
            if (m_pend) begin
                m_act_mid = m_pend_mid;
                m_act_data = m_pend_data;
                m_epoch = ~m_epoch;
                m_issued = '0;
                m_run = 1;
                m_exh = 0;
                m_pend = 0;
            end else if (work_valid) begin
                m_pend_mid = work_midstate;
                m_pend_data = work_data;
                m_pend = 1;
            end
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: sample outputs mid-cycle, away from the active edge.
    always @(negedge hash_clk) begin
        chk("work_ready", {255'd0, work_ready}, {255'd0, !m_pend});
        chk("exhausted", {255'd0, exhausted}, {255'd0, m_exh});
        chk("hasher_data", {128'd0, hasher_data}, {128'd0, m_hd});
        chk("hasher_state", hasher_state, m_hs);
        chk("golden_valid", {255'd0, golden_valid}, {255'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            chk("golden_nonce", {224'd0, golden_nonce}, {224'd0, exp_q[0].nonce});
            chk("golden_epoch", {255'd0, golden_epoch}, {255'd0, exp_q[0].epoch});
        end else if (reset) begin
            chk("golden_nonce_rst", {224'd0, golden_nonce}, 256'd0);
            chk("golden_epoch_rst", {255'd0, golden_epoch}, 256'd0);
        end
`ifdef GOLDEN_FIFO_EN
        chk("overflow", {255'd0, dut.overflow_q}, {255'd0, m_ovf});
`endif
    end

    function automatic logic [31:0] rand_hash();
        logic [31:0] v;
        v = $urandom;
        if (v == MAGIC) v = v ^ 32'h1;
        return v;
    endfunction

    // Drive hw for the current cycle, then advance to just after the next edge.
    task automatic cycle(input logic [31:0] hw);
        hash_word = hw;
        @(posedge hash_clk);
        #1;
    endtask

    task automatic set_work();
        work_midstate = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        work_data = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_random(input int n, input int gold_pct, input int ready_pct,
                              input int work_permille);
        for (int i = 0; i < n; i++) begin
            golden_ready = ($urandom_range(0, 99) < ready_pct);
            work_valid = ($urandom_range(0, 999) < work_permille);
            if (work_valid) set_work();
            cycle(($urandom_range(0, 99) < gold_pct) ? MAGIC : rand_hash());
        end
        work_valid = 1'b0;
    endtask

    initial begin
        work_valid = 1'b0;
        golden_ready = 1'b0;
        work_midstate = '0;
        work_data = '0;
        hash_word = '0;
        repeat (3) cycle(rand_hash());
        reset = 1'b0;

        // Golden hash words while idle: no tags are valid.
        run_random(LAT + 20, 10, 50, 0);

        // First work, then a golden hash word exactly LAT cycles after 0x1000.
        set_work();
        work_valid = 1'b1;
        cycle(rand_hash());
        work_valid = 1'b0;
        for (int i = 0; i < 10000 && m_cnt != 32'h1000 + LAT; i++) begin
            golden_ready = ($urandom_range(0, 1) == 1);
            cycle(($urandom_range(0, 63) == 0) ? MAGIC : rand_hash());
        end
        golden_ready = 1'b1;
        cycle(MAGIC);
        run_random(10, 0, 100, 0);

        // Two back-to-back offers while running: second waits out the promotion.
        set_work();
        work_valid = 1'b1;
        cycle(MAGIC);
        set_work();
        for (int i = 0; i < 4 && m_pend; i++) cycle(MAGIC);
        cycle(MAGIC);
        work_valid = 1'b0;
        run_random(LAT + 40, 40, 80, 0);

        // Drain, then five goldens in a row with the consumer stalled.
        for (int i = 0; i < 20 && (exp_q.size() > 0 || push_due); i++) begin
            golden_ready = 1'b1;
            cycle(rand_hash());
        end
        golden_ready = 1'b0;
        repeat (5) cycle(MAGIC);
        repeat (8) cycle(rand_hash());
        golden_ready = 1'b1;
        repeat (8) cycle(rand_hash());

        // Two nonces short of exhaustion, then goldens for unissued nonces.
        force dut.issue_cnt_q = 33'h0_FFFF_FFFE;
        release dut.issue_cnt_q;
        force_seq++;
        run_random(LAT + 30, 30, 70, 0);

        // New work leaves exhaustion; then reset mid-run with tags in flight.
        set_work();
        work_valid = 1'b1;
        cycle(rand_hash());
        work_valid = 1'b0;
        run_random(LAT + 20, 20, 70, 0);
        reset = 1'b1;
        repeat (2) cycle(MAGIC);
        reset = 1'b0;
        run_random(LAT + 20, 30, 70, 0);

        // Randomised traffic.
        run_random(1500, 12, 50, 8);
        golden_ready = 1'b1;
        repeat (20) cycle(rand_hash());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/miner_work_sequencer.md
MINER_WORK_SEQUENCER -- requirements
Module: miner_work_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LATENCY, default 130: cycles from a nonce on hasher_data to its hash_word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: golden-nonce FIFO entries, power of two.
REQ-003 SHALL have port hash_clk  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port work_valid  input  1  new work offered.
REQ-006 SHALL have port work_ready  output  1  pending buffer empty; work accepted when valid&ready.
REQ-007 SHALL have port work_midstate  input  256  midstate of offered work.
REQ-008 SHALL have port work_data  input  96  fixed header tail of offered work.
REQ-009 SHALL have port hasher_state  output  256  registered midstate to the double-SHA pipeline.
REQ-010 SHALL have port hasher_data  output  128  registered {nonce[31:0], data[95:0]} to the pipeline.
REQ-011 SHALL have port hash_word  input  32  second-hash word [159:128] returned by the pipeline.
REQ-012 SHALL have port golden_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port golden_ready  input  1  consumer pop; pop when valid&ready.
REQ-014 SHALL have port golden_nonce  output  32  FIFO head nonce.
REQ-015 SHALL have port golden_epoch  output  1  FIFO head work epoch bit.
REQ-016 SHALL have port exhausted  output  1  active work has issued all 2^32 nonces.

Function
REQ-017 SHALL keep a 32-bit nonce_cnt that increments by 1 every cycle out of reset, wrapping 0xFFFFFFFF->0, regardless of state.
REQ-018 SHALL implement states IDLE (no work), RUN (issuing), EXH (active work exhausted).
REQ-019 SHALL hold one active and one pending work slot (midstate, data, epoch bit).
REQ-020 SHALL on accept write the pending slot; work_ready SHALL be low while pending is full.
REQ-021 IDLE->RUN when pending is full: pending moves to active, epoch toggles, issue count clears, pending empties; same promotion SHALL happen from RUN or EXH whenever pending is full.
REQ-022 Accept and promotion in the same cycle SHALL not occur; promotion takes priority, accept waits one cycle.
REQ-023 In RUN, each cycle SHALL register hasher_state<=active midstate, hasher_data<={nonce_cnt, active data}, and push tag {1, epoch} into a PIPE_LATENCY-deep tag shift register.
REQ-024 In IDLE or EXH SHALL push tag {0, x}; hasher outputs hold their last values.
REQ-025 SHALL count issued nonces in a 33-bit counter; on reaching 2^32, RUN->EXH and exhausted=1; exhausted clears on promotion.
REQ-026 SHALL compute golden = (hash_word + 32'h5be0cd19 == 0) AND tag-register output valid, registered one cycle.
REQ-027 On registered golden SHALL push {nonce_cnt - PIPE_LATENCY - 1 mod 2^32, tag epoch} into the FIFO; this equals the issued nonce.
REQ-028 FIFO full with a push SHALL drop the new entry and set sticky internal overflow flag, cleared only by reset.
REQ-029 Simultaneous push and pop on a full FIFO SHALL succeed both.
REQ-030 golden_nonce/golden_epoch SHALL be stable while golden_valid=1 and golden_ready=0.

Reset
REQ-031 On reset SHALL asynchronously force: state IDLE, nonce_cnt=0, both slots empty, epoch=0, tags invalid, FIFO empty, overflow=0.
REQ-032 Reset values: work_ready=1, hasher_state=0, hasher_data=0, golden_valid=0, golden_nonce=0, golden_epoch=0, exhausted=0.
REQ-033 Reset mid-run SHALL discard in-flight tags so no stale golden reports after release.

Configuration
REQ-034 Macro GOLDEN_FIFO_EN defined: FIFO of FIFO_DEPTH entries per REQ-027..030.
REQ-035 GOLDEN_FIFO_EN undefined: single register; a new golden overwrites it, golden_valid set on write, cleared on pop; same-cycle write and pop leaves new entry valid.

Verification
REQ-036 Reset, offer work M/D -> accepted cycle 0, RUN, first hasher_data nonce equals nonce_cnt at issue, epoch=1.
REQ-037 Model drives hash_word=32'ha41f32e7 exactly 130 cycles after nonce 0x00001000 issued -> golden_nonce=0x00001000, golden_epoch=1.
REQ-038 Same hash_word while tag invalid (IDLE) -> no golden_valid.
REQ-039 Second work offered while running -> work_ready low until promotion; goldens across boundary carry correct epochs.
REQ-040 Five goldens with golden_ready=0, depth 4 -> four retained in order, fifth dropped, overflow=1.
REQ-041 Force issue counter to 2^32-2 -> two more nonces issued, then EXH, exhausted=1, tags invalid.
